// File: rtl/glitch_sweep_sequencer.sv
// Register-programmed glitch parameter sweep: walks a delay x duration grid,
// repeats each point REPEAT times, arms the external glitcher per attempt and
// records the first hit, attempt count and timeout status.
module glitch_sweep_sequencer #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
   parameter logic [7:0]  ARM_CODE       = 8'h01
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_reg_valid,
   output logic        o_reg_ready,
   input  logic [5:0]  i_reg_addr,
   input  logic [3:0]  i_reg_wstrb,
   input  logic [31:0] i_reg_wdata,
   output logic [31:0] o_reg_rdata,
   output logic        o_glitch_delay_DV,
   output logic [31:0] o_glitch_delay,
   output logic        o_glitch_duration_DV,
   output logic [31:0] o_glitch_duration,
   output logic        o_glitch_ctrl_DV,
   output logic [7:0]  o_glitch_ctrl,
   input  logic        i_glitch_done,
   input  logic        i_attempt_hit,
   output logic        o_irq
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_DLY, S_LOAD_DUR, S_ARM, S_WAIT, S_NEXT, S_DONE
   } state_t;

   state_t      state, state_nx;

   logic        stop_on_hit;
   logic [31:0] dly_start, dly_stop, dly_step;
   logic [31:0] dur_start, dur_stop, dur_step;
   logic [7:0]  rep_cfg;
   logic        done, timeout, hit, hit_this;
   logic [31:0] hit_dly, hit_dur, attempts;
   logic [31:0] cur_dly, cur_dur, tmo_cnt;
   logic [7:0]  rep;
   logic        abort_q;

   logic [3:0]  idx;
   logic        wr, ctrl_wr, busy, start_req, abort_req;
   logic [32:0] dly_sum, dur_sum;
   logic        dly_exh, dur_exh, rep_more, tmo_hit;
   logic [7:0]  rep_lim;
   logic        dly_dv, dur_dv, ctl_dv;
   logic [7:0]  ctl_val;
   logic        rep_inc, dur_adv, dly_adv, tmo_fire;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^i_reg_addr[1:0];

   assign idx       = i_reg_addr[5:2];
   assign wr        = i_reg_valid && (i_reg_wstrb != '0);
   assign ctrl_wr   = wr && (idx == 4'd0);
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign abort_req = ctrl_wr && i_reg_wdata[1] && busy;
   // abort beats start when both bits arrive in one write
   assign start_req = ctrl_wr && i_reg_wdata[0] && !i_reg_wdata[1] && (state == S_IDLE);

   assign dly_sum  = {1'b0, cur_dly} + {1'b0, dly_step};
   assign dur_sum  = {1'b0, cur_dur} + {1'b0, dur_step};
   assign dly_exh  = dly_sum[32] || (dly_sum > {1'b0, dly_stop}) || (dly_step == '0);
   assign dur_exh  = dur_sum[32] || (dur_sum > {1'b0, dur_stop}) || (dur_step == '0);
   assign rep_lim  = (rep_cfg == '0) ? 8'd1 : rep_cfg;
   assign rep_more = ({1'b0, rep} + 9'd1) < {1'b0, rep_lim};
   assign tmo_hit  = ({1'b0, tmo_cnt} + 33'd1) >= {1'b0, TIMEOUT_CYCLES};

   assign o_reg_ready          = i_reg_valid;
   assign o_irq                = done;
   assign o_glitch_delay_DV    = dly_dv;
   assign o_glitch_delay       = dly_dv ? cur_dly : '0;
   assign o_glitch_duration_DV = dur_dv;
   assign o_glitch_duration    = dur_dv ? cur_dur : '0;
   assign o_glitch_ctrl_DV     = ctl_dv;
   assign o_glitch_ctrl        = ctl_val;

   // state register
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) state <= S_IDLE;
      else       state <= state_nx;
   end

   // next-state decode, load strobes and datapath step controls
   always_comb begin
      state_nx = state;
      dly_dv   = 1'b0;
      dur_dv   = 1'b0;
      ctl_dv   = 1'b0;
      ctl_val  = '0;
      rep_inc  = 1'b0;
      dur_adv  = 1'b0;
      dly_adv  = 1'b0;
      tmo_fire = 1'b0;
      // the disarm after an abort lands in IDLE, where nothing else drives a strobe
      if (abort_q) ctl_dv = 1'b1;
      case (state)
         S_IDLE:     if (start_req) state_nx = S_LOAD_DLY;
         S_LOAD_DLY: begin
            dly_dv   = 1'b1;
            state_nx = S_LOAD_DUR;
         end
         S_LOAD_DUR: begin
            dur_dv   = 1'b1;
            state_nx = S_ARM;
         end
         S_ARM: begin
            ctl_dv   = 1'b1;
            ctl_val  = ARM_CODE;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (i_glitch_done) begin
               state_nx = S_NEXT;
            end else if (tmo_hit && !abort_req) begin
               tmo_fire = 1'b1;
               ctl_dv   = 1'b1;
               state_nx = S_DONE;
            end
         end
         S_NEXT: begin
            if (hit_this && stop_on_hit) begin
               state_nx = S_DONE;
            end else if (rep_more) begin
               rep_inc  = 1'b1;
               state_nx = S_ARM;
            end else if (!dur_exh) begin
               dur_adv  = 1'b1;
               state_nx = S_LOAD_DUR;
            end else if (!dly_exh) begin
               dly_adv  = 1'b1;
               state_nx = S_LOAD_DLY;
            end else begin
               state_nx = S_DONE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (abort_req) begin
         state_nx = S_IDLE;
         rep_inc  = 1'b0;
         dur_adv  = 1'b0;
         dly_adv  = 1'b0;
      end
   end

   // configuration registers, sweep position, counters and status flags
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         stop_on_hit <= 1'b0;
         dly_start   <= '0;
         dly_stop    <= '0;
         dly_step    <= '0;
         dur_start   <= '0;
         dur_stop    <= '0;
         dur_step    <= '0;
         rep_cfg     <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         hit         <= 1'b0;
         hit_this    <= 1'b0;
         hit_dly     <= '0;
         hit_dur     <= '0;
         attempts    <= '0;
         cur_dly     <= '0;
         cur_dur     <= '0;
         tmo_cnt     <= '0;
         rep         <= '0;
         abort_q     <= 1'b0;
      end else begin
         abort_q <= abort_req;
         if (wr && !busy) begin
            case (idx)
               4'd1:    dly_start <= i_reg_wdata;
               4'd2:    dly_stop  <= i_reg_wdata;
               4'd3:    dly_step  <= i_reg_wdata;
               4'd4:    dur_start <= i_reg_wdata;
               4'd5:    dur_stop  <= i_reg_wdata;
               4'd6:    dur_step  <= i_reg_wdata;
               4'd7:    rep_cfg   <= i_reg_wdata[7:0];
               default: ;
            endcase
         end
         if (ctrl_wr) stop_on_hit <= i_reg_wdata[2];
         if (start_req) begin
            done     <= 1'b0;
            timeout  <= 1'b0;
            hit      <= 1'b0;
            attempts <= '0;
            cur_dly  <= dly_start;
            cur_dur  <= dur_start;
            rep      <= '0;
         end
         if (state == S_ARM)       tmo_cnt <= '0;
         else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 32'd1;
         if ((state == S_WAIT) && i_glitch_done && !abort_req) begin
            if (attempts != '1) attempts <= attempts + 32'd1;
            hit_this <= i_attempt_hit;
            if (i_attempt_hit && !hit) begin
               hit     <= 1'b1;
               hit_dly <= cur_dly;
               hit_dur <= cur_dur;
            end
         end
         if (tmo_fire) timeout <= 1'b1;
         if (rep_inc)  rep <= rep + 8'd1;
         if (dur_adv) begin
            rep     <= '0;
            cur_dur <= dur_sum[31:0];
         end
         if (dly_adv) begin
            rep     <= '0;
            cur_dur <= dur_start;
            cur_dly <= dly_sum[31:0];
         end
         if (state == S_DONE) done <= 1'b1;
      end
   end

   // register read mux
   always_comb begin
      o_reg_rdata = '0;
      case (idx)
         4'd0:    o_reg_rdata = {29'b0, stop_on_hit, 2'b0};
         4'd1:    o_reg_rdata = dly_start;
         4'd2:    o_reg_rdata = dly_stop;
         4'd3:    o_reg_rdata = dly_step;
         4'd4:    o_reg_rdata = dur_start;
         4'd5:    o_reg_rdata = dur_stop;
         4'd6:    o_reg_rdata = dur_step;
         4'd7:    o_reg_rdata = {24'b0, rep_cfg};
         4'd8:    o_reg_rdata = {28'b0, hit, timeout, done, busy};
         4'd9:    o_reg_rdata = hit_dly;
         4'd10:   o_reg_rdata = hit_dur;
         4'd11:   o_reg_rdata = attempts;
         default: o_reg_rdata = '0;
      endcase
   end

endmodule

// File: doc/glitch_sweep_sequencer.md
GLITCH_SWEEP_SEQUENCER -- requirements
Module: glitch_sweep_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd1000000, setting the clock cycles allowed per attempt before timeout.
REQ-002 SHALL have parameter ARM_CODE, default 8'h01, the ctrl byte that arms the glitcher.
REQ-003 SHALL have port i_Clk, input, 1: single system clock; all logic on posedge.
REQ-004 SHALL have port i_Rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_reg_valid, input, 1: register access request.
REQ-006 SHALL have port o_reg_ready, output, 1: access accepted; equals i_reg_valid, combinational.
REQ-007 SHALL have port i_reg_addr, input, 6: byte offset; bits [1:0] ignored.
REQ-008 SHALL have ports i_reg_wstrb (input, 4), i_reg_wdata (input, 32) and o_reg_rdata (output, 32); a write is any access with wstrb nonzero.
REQ-009 SHALL have ports o_glitch_delay_DV (output, 1) and o_glitch_delay (output, 32): delay load strobe and value.
REQ-010 SHALL have ports o_glitch_duration_DV (output, 1) and o_glitch_duration (output, 32): duration load strobe and value.
REQ-011 SHALL have ports o_glitch_ctrl_DV (output, 1) and o_glitch_ctrl (output, 8): ctrl write strobe and value.
REQ-012 SHALL have ports i_glitch_done (input, 1, one-cycle attempt-complete pulse) and i_attempt_hit (input, 1, sampled with done).
REQ-013 SHALL have port o_irq, output, 1: level, high while STATUS.done=1.

Function
REQ-014 SHALL map registers: 0x00 CTRL (W: bit0 start, bit1 abort, bit2 stop_on_hit); 0x04/0x08/0x0C DLY_START/STOP/STEP; 0x10/0x14/0x18 DUR_START/STOP/STEP; 0x1C REPEAT[7:0]; 0x20 STATUS (RO: bit0 busy, bit1 done, bit2 timeout, bit3 hit); 0x24 HIT_DLY; 0x28 HIT_DUR; 0x2C ATTEMPTS; other offsets read 0, writes ignored.
REQ-015 SHALL drive o_reg_rdata combinationally from i_reg_addr; reading CTRL returns {29'b0, stop_on_hit, 2'b0}.
REQ-016 SHALL ignore writes to 0x04-0x1C while busy.
REQ-017 SHALL implement FSM IDLE, LOAD_DLY, LOAD_DUR, ARM, WAIT, NEXT, DONE.
REQ-018 IDLE, start write: clear done/timeout/hit/ATTEMPTS, cur_dly=DLY_START, cur_dur=DUR_START, rep=0 -> LOAD_DLY; start while busy ignored.
REQ-019 LOAD_DLY: o_glitch_delay_DV=1 one cycle, o_glitch_delay=cur_dly -> LOAD_DUR.
REQ-020 LOAD_DUR: o_glitch_duration_DV=1 one cycle, o_glitch_duration=cur_dur -> ARM.
REQ-021 ARM: o_glitch_ctrl_DV=1 one cycle, o_glitch_ctrl=ARM_CODE, timeout counter cleared -> WAIT.
REQ-022 WAIT: on i_glitch_done, ATTEMPTS+1 (saturating at 32'hFFFFFFFF); if i_attempt_hit and hit=0, latch HIT_DLY=cur_dly, HIT_DUR=cur_dur, set hit -> NEXT.
REQ-023 WAIT: counter reaching TIMEOUT_CYCLES without done sets timeout, issues ctrl_DV with 8'h00 -> DONE.
REQ-024 NEXT priority: (a) hit this attempt and stop_on_hit -> DONE; (b) rep+1<REPEAT -> rep+1, ARM; (c) rep=0, advance duration -> LOAD_DUR; (d) duration wrapped -> cur_dur=DUR_START, advance delay -> LOAD_DLY; (e) delay exhausted -> DONE.
REQ-025 Advance SHALL compute 33-bit sum cur+STEP; dimension exhausted if carry, sum>STOP, or STEP=0.
REQ-026 REPEAT=0 SHALL behave as 1.
REQ-027 DONE: set done, clear busy -> IDLE; busy=1 in all other non-IDLE states.
REQ-028 Abort write while busy: ctrl_DV with 8'h00 next cycle, -> IDLE, done not set; abort in IDLE ignored; abort with start in same write: abort wins.
REQ-029 i_glitch_done outside WAIT SHALL be ignored.
REQ-030 At most one of the three DV outputs SHALL be high in any cycle.

Reset
REQ-031 On i_Rst: FSM IDLE, all registers, counters, flags 0, all outputs 0; asserts asynchronously, mid-sweep included, with no DV emitted.

Verification
REQ-032 DLY 10..12 step 1, DUR 5..6 step 1, REPEAT 1, done pulse 5 cycles after each arm -> 6 attempts in order (10,5),(10,6),(11,5)...(12,6); ATTEMPTS=6, done=1, o_irq=1.
REQ-033 Same sweep, hit asserted on 3rd attempt, stop_on_hit=1 -> HIT_DLY=11, HIT_DUR=5, ATTEMPTS=3, hit=1, done=1.
REQ-034 No done pulse, TIMEOUT_CYCLES=100 -> timeout=1, ctrl 8'h00 issued 100 cycles after arm, done=1, ATTEMPTS=0.
REQ-035 DLY_START=32'hFFFFFFFE, STOP=32'hFFFFFFFF, STEP=2, single duration -> one attempt, no wrap to small delays.
REQ-036 REPEAT=3, one point -> 3 arms, one delay and one duration load; abort during 2nd WAIT -> ctrl 8'h00, busy=0, done=0.
REQ-037 i_Rst asserted mid-WAIT -> all outputs 0 immediately, STATUS=0.
